// File: rtl/riscv_pkg.sv
// Shared RV32IM definitions: opcodes, ALU/result/operand-select encodings,
// the decoded control bundle and the operand-usage decode helpers.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_SLL    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;
  localparam logic [4:0] ALU_PASSB  = 5'd18;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ASEL_RS1  = 2'b00;
  localparam logic [1:0] ASEL_PC   = 2'b01;
  localparam logic [1:0] ASEL_ZERO = 2'b10;

  // Decoded control bundle; all-zero is a NOP.
  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       MemRead;
    logic       ALUSrc;
    logic       Branch;
    logic       Jump;
    logic       JumpReg;
    logic       B_Zero;
    logic [1:0] ResultSrc;
    logic [4:0] ALUControl;
    logic [1:0] isPC_select;
  } ctrl_t;

  // What the ID/EX register does on the coming edge, highest priority first.
  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_LOAD   = 2'd3
  } stage_act_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  // Strip every side effect so the slot becomes harmless; leave the
  // non-committing fields alone to avoid needless toggling.
  function automatic ctrl_t kill_ctrl(input ctrl_t c);
    ctrl_t k;
    k          = c;
    k.RegWrite = 1'b0;
    k.MemWrite = 1'b0;
    k.MemRead  = 1'b0;
    k.Branch   = 1'b0;
    k.Jump     = 1'b0;
    k.JumpReg  = 1'b0;
    return k;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side bundle handed from IF/ID + decode into the ID/EX register.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            if_id_valid_i;
  logic [XLEN-1:0] if_id_pc_i;
  logic [31:0]     if_id_instr_i;
  logic [XLEN-1:0] rd1_i;
  logic [XLEN-1:0] rd2_i;
  logic [XLEN-1:0] imm_i;
  logic            RegWrite_i;
  logic            MemWrite_i;
  logic            MemRead_i;
  logic            ALUSrc_i;
  logic            Branch_i;
  logic            Jump_i;
  logic            JumpReg_i;
  logic            B_Zero_i;
  logic [1:0]      ResultSrc_i;
  logic [4:0]      ALUControl_i;
  logic [1:0]      isPC_select_i;

  modport master (
    output if_id_valid_i, if_id_pc_i, if_id_instr_i, rd1_i, rd2_i, imm_i,
           RegWrite_i, MemWrite_i, MemRead_i, ALUSrc_i, Branch_i, Jump_i,
           JumpReg_i, B_Zero_i, ResultSrc_i, ALUControl_i, isPC_select_i
  );

  modport slave (
    input  if_id_valid_i, if_id_pc_i, if_id_instr_i, rd1_i, rd2_i, imm_i,
           RegWrite_i, MemWrite_i, MemRead_i, ALUSrc_i, Branch_i, Jump_i,
           JumpReg_i, B_Zero_i, ResultSrc_i, ALUControl_i, isPC_select_i
  );
endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
// x0 is never a hazard, and operands the opcode does not read are ignored.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [6:0] opcode_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // Pure compare of ID source indices against the pending load destination.
  always_comb begin
    ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0);
    rs1_hit    = uses_rs1(opcode_i) & (rs1_i == ex_rd_i);
    rs2_hit    = uses_rs2(opcode_i) & (rs2_i == ex_rd_i);
    load_use_o = ex_is_load & id_valid_i & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decode results for EX, inserts bubbles on
// load-use hazards, flushes on EX redirect, holds while EX is busy, and keeps
// a saturating count of hazard/flush bubbles for performance debug.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_if.slave     id_bus,
  input  logic             ex_redirect_i,
  input  logic             ex_stall_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  ex_rd1_o,
  output logic [XLEN-1:0]  ex_rd2_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic             ex_RegWrite_o,
  output logic             ex_MemWrite_o,
  output logic             ex_MemRead_o,
  output logic             ex_ALUSrc_o,
  output logic             ex_Branch_o,
  output logic             ex_Jump_o,
  output logic             ex_JumpReg_o,
  output logic             ex_B_Zero_o,
  output logic [1:0]       ex_ResultSrc_o,
  output logic [4:0]       ex_ALUControl_o,
  output logic [1:0]       ex_isPC_select_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  ctrl_t           id_ctrl;
  logic [6:0]      id_opcode;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            unused_instr_bits;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rd1_q, rd1_d;
  logic [XLEN-1:0] rd2_q, rd2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  stage_act_e      act;
  logic            load_use;
  logic            cnt_inc;

  assign id_opcode = id_bus.if_id_instr_i[6:0];
  assign id_rd     = id_bus.if_id_instr_i[11:7];
  assign id_rs1    = id_bus.if_id_instr_i[19:15];
  assign id_rs2    = id_bus.if_id_instr_i[24:20];
  // funct3/funct7 are consumed by decode upstream, not by this register.
  assign unused_instr_bits = ^{id_bus.if_id_instr_i[31:25], id_bus.if_id_instr_i[14:12]};

  // Gather the loose decode signals into one bundle.
  always_comb begin
    id_ctrl             = '0;
    id_ctrl.RegWrite    = id_bus.RegWrite_i;
    id_ctrl.MemWrite    = id_bus.MemWrite_i;
    id_ctrl.MemRead     = id_bus.MemRead_i;
    id_ctrl.ALUSrc      = id_bus.ALUSrc_i;
    id_ctrl.Branch      = id_bus.Branch_i;
    id_ctrl.Jump        = id_bus.Jump_i;
    id_ctrl.JumpReg     = id_bus.JumpReg_i;
    id_ctrl.B_Zero      = id_bus.B_Zero_i;
    id_ctrl.ResultSrc   = id_bus.ResultSrc_i;
    id_ctrl.ALUControl  = id_bus.ALUControl_i;
    id_ctrl.isPC_select = id_bus.isPC_select_i;
  end

  load_use_detect u_load_use_detect (
    .id_valid_i    (id_bus.if_id_valid_i),
    .opcode_i      (id_opcode),
    .rs1_i         (id_rs1),
    .rs2_i         (id_rs2),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.MemRead),
    .ex_rd_i       (rd_q),
    .load_use_o    (load_use)
  );

  // Resolve this edge's action; a redirect makes any stall reason moot.
  always_comb begin
    act = ACT_LOAD;
    if (ex_redirect_i) begin
      act = ACT_FLUSH;
    end else if (ex_stall_i) begin
      act = ACT_HOLD;
    end else if (load_use || !id_bus.if_id_valid_i) begin
      act = ACT_BUBBLE;
    end
  end

  // Front-end hold; forced low in reset so it reflects the cleared EX slot.
  assign stall_o = rst & ~ex_redirect_i & (ex_stall_i | load_use);

  // Next-state for the EX slot and the bubble counter.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    cnt_inc = 1'b0;
    unique case (act)
      ACT_FLUSH: begin
        valid_d = 1'b0;
        ctrl_d  = kill_ctrl(ctrl_q);
        cnt_inc = 1'b1;
      end
      ACT_HOLD: begin
      end
      ACT_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = kill_ctrl(ctrl_q);
        // An empty IF/ID slot is not a lost cycle worth counting.
        cnt_inc = load_use;
      end
      ACT_LOAD: begin
        valid_d = 1'b1;
        pc_d    = id_bus.if_id_pc_i;
        rd1_d   = id_bus.rd1_i;
        rd2_d   = id_bus.rd2_i;
        imm_d   = id_bus.imm_i;
        rs1_d   = id_rs1;
        rs2_d   = id_rs2;
        rd_d    = id_rd;
        ctrl_d  = id_ctrl;
      end
      default: begin
      end
    endcase
    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // EX slot and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid_o       = valid_q;
  assign ex_pc_o          = pc_q;
  assign ex_rd1_o         = rd1_q;
  assign ex_rd2_o         = rd2_q;
  assign ex_imm_o         = imm_q;
  assign ex_rs1_o         = rs1_q;
  assign ex_rs2_o         = rs2_q;
  assign ex_rd_o          = rd_q;
  assign ex_RegWrite_o    = ctrl_q.RegWrite;
  assign ex_MemWrite_o    = ctrl_q.MemWrite;
  assign ex_MemRead_o     = ctrl_q.MemRead;
  assign ex_ALUSrc_o      = ctrl_q.ALUSrc;
  assign ex_Branch_o      = ctrl_q.Branch;
  assign ex_Jump_o        = ctrl_q.Jump;
  assign ex_JumpReg_o     = ctrl_q.JumpReg;
  assign ex_B_Zero_o      = ctrl_q.B_Zero;
  assign ex_ResultSrc_o   = ctrl_q.ResultSrc;
  assign ex_ALUControl_o  = ctrl_q.ALUControl;
  assign ex_isPC_select_o = ctrl_q.isPC_select;
  assign bubble_cnt_o     = cnt_q;

endmodule
